// File: rtl/stream_slice_reorder.sv
// Handshaked frame accumulator that emits each completed frame as a left-stream
// ({<< s {frame}}) with a per-frame slice size of 1, 2, 4 or 8 bits.
module stream_slice_reorder #(
  parameter int IN_W  = 4,
  parameter int WORDS = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             slice_sel,
  output logic [IN_W*WORDS-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_slice,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   busy
);

  localparam int F  = IN_W * WORDS;
  localparam int CW = $clog2(WORDS + 1);

  if (F % 8 != 0) begin : g_bad_frame_width
    $error("stream_slice_reorder: IN_W*WORDS must be a multiple of 8");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [F-1:0]     frame_q;
  logic [1:0]       slice_q;

  logic [F-1:0]     next_frame;
  logic [1:0]       eff_slice;
  logic             accept;
  logic             last_word;

  // Slices are counted from the MSB and their order reversed; bits inside a slice keep their order.
  function automatic logic [F-1:0] reorder(input logic [F-1:0] f, input logic [1:0] sel);
    logic [F-1:0] r;
    r = '0;
    case (sel)
      2'd0:    for (int i = 0; i < F; i++)     r[i]       = f[F-1-i];
      2'd1:    for (int m = 0; m < F/2; m++)   r[m*2 +: 2] = f[(F/2-1-m)*2 +: 2];
      2'd2:    for (int m = 0; m < F/4; m++)   r[m*4 +: 4] = f[(F/4-1-m)*4 +: 4];
      default: for (int m = 0; m < F/8; m++)   r[m*8 +: 8] = f[(F/8-1-m)*8 +: 8];
    endcase
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_frame = '0;
    eff_slice  = slice_q;
    next_frame = (frame_q << IN_W) | F'(in_data);
    // The first word of a frame uses the live select, which also covers WORDS==1.
    if (count_q == '0) eff_slice = slice_sel;
  end

  assign accept    = in_valid & in_ready;
  assign last_word = (count_q == CW'(WORDS - 1));
  assign busy      = (count_q != '0) | out_valid;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      count_q   <= '0;
      frame_q   <= '0;
      slice_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_slice <= '0;
      in_ready  <= 1'b1;
      frame_cnt <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            frame_q <= next_frame;
            if (count_q == '0) slice_q <= slice_sel;
            if (last_word) begin
              count_q   <= '0;
              state_q   <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= reorder(next_frame, eff_slice);
              out_slice <= eff_slice;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q   <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
